// File: rtl/dataflow_unit_rate_pipe.sv
// Pipelined unit-rate dataflow stage: applies a per-token unary signed op
// (negate / abs / saturating negate / pass) and carries it through DEPTH register stages.
module dataflow_unit_rate_pipe #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic signed [WIDTH-1:0] arg0,
  input  logic                    arg1,
  input  logic                    arg2,
  input  logic [1:0]              arg3,
  output logic                    ret0,
  output logic signed [WIDTH-1:0] ret1,
  output logic                    ret2,
  output logic [CW-1:0]           ret3
);

  localparam logic signed [WIDTH-1:0] S_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH-1:0] S_MAX = {1'b0, {(WIDTH-1){1'b1}}};

  // Negation wraps modulo 2^WIDTH except for the saturating variant.
  function automatic logic signed [WIDTH-1:0] apply_op(
    input logic signed [WIDTH-1:0] x,
    input logic [1:0]              op
  );
    logic signed [WIDTH-1:0] r;
    case (op)
      2'd0:    r = -x;
      2'd1:    r = (x < 0) ? -x : x;
      2'd2:    r = (x == S_MIN) ? S_MAX : -x;
      default: r = x;
    endcase
    return r;
  endfunction

  logic [DEPTH-1:0]        vld_p;
  logic signed [WIDTH-1:0] dat_p [DEPTH];
  logic [DEPTH:0]          en;
  logic signed [WIDTH-1:0] op_res;
  logic [CW-1:0]           occ;

  assign op_res = apply_op(arg0, arg3);

  // Backward ready chain: a stage may load when it is empty or its successor moves.
  always_comb begin
    logic r;
    r = arg2;
    en[DEPTH] = arg2;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      r = ~vld_p[k] | r;
      en[k] = r;
    end
  end

  always_comb begin
    occ = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occ = occ + CW'(vld_p[k]);
    end
  end

  // Stage 0 captures the operated value; later stages shift forward.
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_p <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        dat_p[k] <= '0;
      end
    end else begin
      if (en[0]) begin
        vld_p[0] <= arg1;
        if (arg1) begin
          dat_p[0] <= op_res;
        end
      end
      for (int k = 1; k < DEPTH; k++) begin
        if (en[k]) begin
          vld_p[k] <= vld_p[k-1];
          if (vld_p[k-1]) begin
            dat_p[k] <= dat_p[k-1];
          end
        end
      end
    end
  end

  assign ret0 = en[0];
  assign ret1 = dat_p[DEPTH-1];
  assign ret2 = vld_p[DEPTH-1];
  assign ret3 = occ;

endmodule

// File: tb/tb_dataflow_unit_rate_pipe.sv
// Bench for dataflow_unit_rate_pipe: directed vectors on a DEPTH=2 instance and a
// gapped/stalled stream on a DEPTH=3 instance, both checked through scoreboards.
module tb_dataflow_unit_rate_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: WIDTH=8, DEPTH=2
  logic              reset_a = 1'b1;
  logic signed [7:0] arg0_a  = '0;
  logic              arg1_a  = 1'b0;
  logic              arg2_a  = 1'b0;
  logic [1:0]        arg3_a  = '0;
  logic              ret0_a;
  logic signed [7:0] ret1_a;
  logic              ret2_a;
  logic [1:0]        ret3_a;
  int                expv_a  = 0;
  int                exp_qa[$];
  int                occ_a   = 0;
  int                emit_a  = 0;

  // Instance B: WIDTH=8, DEPTH=3
  logic              reset_b = 1'b1;
  logic signed [7:0] arg0_b  = '0;
  logic              arg1_b  = 1'b0;
  logic              arg2_b  = 1'b0;
  logic [1:0]        arg3_b  = '0;
  logic              ret0_b;
  logic signed [7:0] ret1_b;
  logic              ret2_b;
  logic [1:0]        ret3_b;
  int                expv_b  = 0;
  int                exp_qb[$];
  int                occ_b   = 0;
  int                emit_b  = 0;

  dataflow_unit_rate_pipe #(.WIDTH(8), .DEPTH(2)) u_a (
    .clock(clk), .reset(reset_a), .arg0(arg0_a), .arg1(arg1_a), .arg2(arg2_a),
    .arg3(arg3_a), .ret0(ret0_a), .ret1(ret1_a), .ret2(ret2_a), .ret3(ret3_a)
  );

  dataflow_unit_rate_pipe #(.WIDTH(8), .DEPTH(3)) u_b (
    .clock(clk), .reset(reset_b), .arg0(arg0_b), .arg1(arg1_b), .arg2(arg2_b),
    .arg3(arg3_b), .ret0(ret0_b), .ret1(ret1_b), .ret2(ret2_b), .ret3(ret3_b)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference op for 8-bit tokens, computed in wide integers then wrapped/saturated.
  function automatic int model(input int x, input int op);
    int r;
    case (op)
      0:       r = -x;
      1:       r = (x < 0) ? -x : x;
      2:       r = -x;
      default: r = x;
    endcase
    if (op == 2 && r > 127) r = 127;
    else if (r > 127) r = r - 256;
    return r;
  endfunction

  // Scoreboard monitors
  always @(negedge clk) begin
    if (reset_a) begin
      exp_qa.delete();
      occ_a = 0;
    end else begin
      chk("occ_a", int'(ret3_a), occ_a);
      if (ret2_a && arg2_a) begin
        emit_a++;
        occ_a--;
        if (exp_qa.size() == 0) chk("spurious_a", exp_qa.size(), 1);
        else chk("data_a", int'(ret1_a), exp_qa.pop_front());
      end
      if (arg1_a && ret0_a) begin
        exp_qa.push_back(expv_a);
        occ_a++;
      end
    end
  end

  always @(negedge clk) begin
    if (reset_b) begin
      exp_qb.delete();
      occ_b = 0;
    end else begin
      chk("occ_b", int'(ret3_b), occ_b);
      if (ret2_b && arg2_b) begin
        emit_b++;
        occ_b--;
        if (exp_qb.size() == 0) chk("spurious_b", exp_qb.size(), 1);
        else chk("data_b", int'(ret1_b), exp_qb.pop_front());
      end
      if (arg1_b && ret0_b) begin
        exp_qb.push_back(expv_b);
        occ_b++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input int x, input int op, input int e, input logic v);
    arg0_a = 8'(x);
    arg3_a = 2'(op);
    expv_a = e;
    arg1_a = v;
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sv [3];
    int se [3];
    int ox [5];
    int oo [5];
    int oe [5];
    int tok [4];
    int idx, acc, em, held, n, cyc, x, op;
    logic got;

    step();
    step();
    reset_a = 1'b0;
    reset_b = 1'b0;
    #1;
    chk("rst_ret2", int'(ret2_a), 0);
    chk("rst_ret1", int'(ret1_a), 0);
    chk("rst_ret3", int'(ret3_a), 0);
    chk("rst_ret0", int'(ret0_a), 1);

    // Streaming negate with latency check
    sv = '{5, -7, 0};
    se = '{-5, 7, 0};
    arg2_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_a(sv[i], 0, se[i], 1'b1);
      chk("stream_rdy", int'(ret0_a), 1);
      if (i == 1) chk("lat_empty", int'(ret2_a), 0);
      if (i == 2) begin
        chk("lat_vld", int'(ret2_a), 1);
        chk("lat_data", int'(ret1_a), -5);
      end
      step();
    end
    drive_a(0, 0, 0, 1'b0);
    repeat (4) step();
    chk("stream_drain", exp_qa.size(), 0);

    // Most-negative corner across all ops, then abs of a negative
    ox = '{-128, -128, -128, -128, -3};
    oo = '{0, 1, 2, 3, 1};
    oe = '{-128, -128, 127, -128, 3};
    for (int i = 0; i < 5; i++) begin
      drive_a(ox[i], oo[i], oe[i], 1'b1);
      step();
    end
    drive_a(0, 0, 0, 1'b0);
    repeat (4) step();
    chk("ops_drain", exp_qa.size(), 0);

    // Fill under stall: only DEPTH tokens enter, output holds the first
    tok = '{10, 20, 30, 40};
    arg2_a = 1'b0;
    idx = 0;
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      drive_a(tok[idx], 3, tok[idx], 1'b1);
      if (ret0_a) begin
        acc++;
        idx++;
      end
      step();
    end
    chk("stall_acc", acc, 2);
    chk("stall_rdy", int'(ret0_a), 0);
    chk("stall_occ", int'(ret3_a), 2);
    chk("stall_vld", int'(ret2_a), 1);
    chk("stall_d0", int'(ret1_a), 10);
    step();
    chk("stall_d1", int'(ret1_a), 10);
    arg2_a = 1'b1;
    for (int c = 0; c < 10 && idx < 4; c++) begin
      drive_a(tok[idx], 3, tok[idx], 1'b1);
      if (ret0_a) idx++;
      step();
    end
    chk("stall_sent", idx, 4);
    drive_a(0, 0, 0, 1'b0);
    repeat (4) step();
    chk("stall_drain", exp_qa.size(), 0);

    // Full pipe with simultaneous accept and emit
    arg2_a = 1'b0;
    drive_a(100, 3, 100, 1'b1);
    step();
    drive_a(101, 3, 101, 1'b1);
    step();
    chk("full_fill", int'(ret3_a), 2);
    arg2_a = 1'b1;
    acc = 0;
    em = 0;
    for (int c = 0; c < 10; c++) begin
      drive_a(c * 3 + 1, 0, -(c * 3 + 1), 1'b1);
      chk("full_rdy", int'(ret0_a), 1);
      if (ret0_a) acc++;
      if (ret2_a) em++;
      step();
      chk("full_occ", int'(ret3_a), 2);
    end
    chk("full_acc", acc, 10);
    chk("full_emit", em, 10);
    drive_a(0, 0, 0, 1'b0);
    repeat (4) step();
    chk("full_drain", exp_qa.size(), 0);

    // Reset with two tokens in flight
    arg2_a = 1'b0;
    drive_a(55, 3, 55, 1'b1);
    step();
    drive_a(66, 3, 66, 1'b1);
    step();
    drive_a(0, 0, 0, 1'b0);
    chk("mid_occ", int'(ret3_a), 2);
    reset_a = 1'b1;
    step();
    reset_a = 1'b0;
    #1;
    chk("mid_ret2", int'(ret2_a), 0);
    chk("mid_ret1", int'(ret1_a), 0);
    chk("mid_ret3", int'(ret3_a), 0);
    chk("mid_ret0", int'(ret0_a), 1);
    held = emit_a;
    arg2_a = 1'b1;
    repeat (5) step();
    chk("mid_noemit", emit_a, held);

    // Gapped input with alternating downstream ready on DEPTH=3
    n = 0;
    cyc = 0;
    while (n < 1000 && cyc < 20000) begin
      arg2_b = (cyc % 2 == 0);
      if (!arg1_b && $urandom_range(0, 3) != 0) begin
        x = int'($urandom_range(0, 255)) - 128;
        op = int'($urandom_range(0, 3));
        arg0_b = 8'(x);
        arg3_b = 2'(op);
        expv_b = model(x, op);
        arg1_b = 1'b1;
      end
      #1;
      got = arg1_b && ret0_b;
      step();
      if (got) begin
        n++;
        arg1_b = 1'b0;
      end
      cyc++;
    end
    chk("rand_sent", n, 1000);
    arg1_b = 1'b0;
    arg2_b = 1'b1;
    repeat (6) step();
    chk("rand_emit", emit_b, 1000);
    chk("rand_drain", exp_qb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
